// File: rtl/rinsn_encoder.sv
// R-type instruction encoder with a 2-entry in-order output buffer and illegal-op error pulse.
// Optional pop counter output enc_count is enabled by defining RINSN_ENCODER_COUNT_EN.
module rinsn_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic        err
`ifdef RINSN_ENCODER_COUNT_EN
  ,
  output logic [15:0] enc_count
`endif
);

  localparam logic [6:0] OpcodeOp = 7'b0110011;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic        err_q;

  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic [6:0]  funct7;
  logic [31:0] word;

  // Only SUB and SRA may carry the alt bit.
  assign legal  = ~in_op[3] | (in_op[2:0] == 3'b000) | (in_op[2:0] == 3'b101);
  assign accept = in_valid & in_ready;
  assign push   = accept & legal;
  assign pop    = out_valid & out_ready;
  assign funct7 = in_op[3] ? 7'b0100000 : 7'b0000000;
  assign word   = {funct7, in_rs2, in_rs1, in_op[2:0], in_rd, OpcodeOp};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (push) state_d = StOne;
      StOne: begin
        if (push && !pop)      state_d = StFull;
        else if (!push && pop) state_d = StEmpty;
      end
      StFull:  if (pop) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StEmpty;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      err_q    <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= accept & ~legal;
      if (push) begin
        mem_q[wr_ptr_q] <= word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q != StFull);
    out_valid = (state_q != StEmpty);
    out_insn  = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    err       = err_q;
  end

`ifdef RINSN_ENCODER_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign enc_count = count_q;
`endif

endmodule
